multicycle_control_unit: RTL and testbench



---
 rtl/multicycle_control_unit.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with a variable-latency RAM handshake, bus timeout and illegal-opcode trap.
// Optional retire counter output (instret) is built when CU_RETIRE_CNT_EN is defined.
module multicycle_control_unit #(
    parameter int BUS_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instrCode,
    input  logic              busReady,
    output logic              irWe,
    output logic              PCEn,
    output logic              regFileWe,
    output logic              aluSrcMuxSel,
    output logic [3:0]        aluControl,
    output logic [2:0]        strb,
    output logic [2:0]        RFWDSrcMuxSel,
    output logic              branch,
    output logic              jal,
    output logic              jalr,
    output logic              busReq,
    output logic              busWe,
    output logic              illegalInstr,
    output logic              busErr,
`ifdef CU_RETIRE_CNT_EN
    output logic [CNT_W-1:0]  instret,
`endif
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE,
        JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
    } state_t;

    // Counter only needs to reach BUS_TIMEOUT-1; the limit-th idle cycle traps.
    localparam int            TW    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [TW-1:0] LIMIT = TW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
    localparam bit            TO_EN = (BUS_TIMEOUT > 0);

    state_t        cur_st;
    state_t        nxt_st;
    logic [TW-1:0] tcnt;
    logic          in_mem;
    logic          timeout;
    logic          bad_op;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          f7b;
    logic          unused_instr;

    assign opcode       = instrCode[6:0];
    assign funct3       = instrCode[14:12];
    assign f7b          = instrCode[30];
    assign strb         = funct3;
    assign state        = cur_st;
    assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    assign in_mem  = (cur_st == S_MEM) || (cur_st == L_MEM);
    assign timeout = TO_EN && in_mem && !busReady && (tcnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_st       <= FETCH;
            tcnt         <= '0;
            illegalInstr <= 1'b0;
            busErr       <= 1'b0;
        end else begin
            cur_st <= nxt_st;
            if (!in_mem)
                tcnt <= '0;
            else if (TO_EN && !busReady && (tcnt != LIMIT))
                tcnt <= tcnt + TW'(1);
            if (bad_op)
                illegalInstr <= 1'b1;
            if (timeout)
                busErr <= 1'b1;
        end
    end

    always_comb begin
        nxt_st        = cur_st;
        bad_op        = 1'b0;
        irWe          = 1'b0;
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        aluControl    = 4'b0000;
        RFWDSrcMuxSel = 3'b000;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        busReq        = 1'b0;
        busWe         = 1'b0;
        case (cur_st)
            FETCH: begin
                irWe   = 1'b1;
                nxt_st = DECODE;
            end
            DECODE: begin
                case (opcode)
                    7'b0110011: nxt_st = R_EXE;
                    7'b0010011: nxt_st = I_EXE;
                    7'b1100011: nxt_st = B_EXE;
                    7'b0110111: nxt_st = LU_EXE;
                    7'b0010111: nxt_st = AU_EXE;
                    7'b1101111: nxt_st = J_EXE;
                    7'b1100111: nxt_st = JL_EXE;
                    7'b0100011: nxt_st = S_EXE;
                    7'b0000011: nxt_st = L_EXE;
                    default: begin
                        nxt_st = TRAP;
                        bad_op = 1'b1;
                    end
                endcase
            end
            R_EXE: begin
                regFileWe  = 1'b1;
                PCEn       = 1'b1;
                aluControl = {f7b, funct3};
                nxt_st     = FETCH;
            end
            I_EXE: begin
                regFileWe    = 1'b1;
                aluSrcMuxSel = 1'b1;
                PCEn         = 1'b1;
                // Only SRAI carries a meaningful bit 30; other immediates may set it freely.
                aluControl   = ({f7b, funct3} == 4'b1101) ? 4'b1101 : {1'b0, funct3};
                nxt_st       = FETCH;
            end
            B_EXE: begin
                PCEn       = 1'b1;
                branch     = 1'b1;
                aluControl = {f7b, funct3};
                nxt_st     = FETCH;
            end
            LU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b010;
                PCEn          = 1'b1;
                nxt_st        = FETCH;
            end
            AU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b011;
                PCEn          = 1'b1;
                nxt_st        = FETCH;
            end
            J_EXE, JL_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b100;
                jal           = 1'b1;
                PCEn          = 1'b1;
                jalr          = (cur_st == JL_EXE);
                aluSrcMuxSel  = (cur_st == JL_EXE);
                nxt_st        = FETCH;
            end
            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                nxt_st       = S_MEM;
            end
            S_MEM: begin
                busReq       = 1'b1;
                busWe        = 1'b1;
                aluSrcMuxSel = 1'b1;
                if (busReady) begin
                    PCEn   = 1'b1;
                    nxt_st = FETCH;
                end else if (timeout) begin
                    nxt_st = TRAP;
                end
            end
            L_EXE: begin
                aluSrcMuxSel = 1'b1;
                nxt_st       = L_MEM;
            end
            L_MEM: begin
                busReq       = 1'b1;
                aluSrcMuxSel = 1'b1;
                if (busReady)
                    nxt_st = L_WB;
                else if (timeout)
                    nxt_st = TRAP;
            end
            L_WB: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                PCEn          = 1'b1;
                nxt_st        = FETCH;
            end
            TRAP:    nxt_st = TRAP;
            default: nxt_st = FETCH;
        endcase
    end

`ifdef CU_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= '0;
        else if (PCEn)
            instret <= instret + CNT_W'(1);
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: expected per-cycle control vectors are queued, then popped and compared.
module tb_multicycle_control_unit;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, RE = 4'd2, IE = 4'd3, BE = 4'd4, LUE = 4'd5,
                           AUE = 4'd6, JE = 4'd7, JLE = 4'd8, SE = 4'd9, SM = 4'd10, LE = 4'd11,
                           LM = 4'd12, LW = 4'd13, TR = 4'd14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        irWe, PCEn, regFileWe, aluSrcMuxSel;
    logic [3:0]  aluControl;
    logic [2:0]  strb, RFWDSrcMuxSel;
    logic        branch, jal, jalr, busReq, busWe, illegalInstr, busErr;
    logic [3:0]  state;
`ifdef CU_RETIRE_CNT_EN
    logic [3:0]  instret;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;
    exp_t sb[$];

    multicycle_control_unit #(.BUS_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
        .irWe(irWe), .PCEn(PCEn), .regFileWe(regFileWe), .aluSrcMuxSel(aluSrcMuxSel),
        .aluControl(aluControl), .strb(strb), .RFWDSrcMuxSel(RFWDSrcMuxSel),
        .branch(branch), .jal(jal), .jalr(jalr), .busReq(busReq), .busWe(busWe),
        .illegalInstr(illegalInstr), .busErr(busErr),
`ifdef CU_RETIRE_CNT_EN
        .instret(instret),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    // Field order: state, irWe, PCEn, regFileWe, aluSrc, aluControl, RFWD, branch, jal, jalr, busReq, busWe, illegal, busErr
    function automatic logic [21:0] ev(input logic [3:0] st, input logic ir, input logic pc,
                                       input logic rf, input logic as, input logic [3:0] alu,
                                       input logic [2:0] wd, input logic br, input logic j,
                                       input logic jr, input logic rq, input logic we,
                                       input logic il, input logic be);
        return {ir, pc, rf, as, alu, wd, br, j, jr, rq, we, il, be, st};
    endfunction

    task automatic push(input string tag, input logic [21:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic cmp();
        exp_t        e;
        logic [21:0] obs;
        obs = {irWe, PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel, branch, jal, jalr,
               busReq, busWe, illegalInstr, busErr, state};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
        checks++;
        assert (strb === instrCode[14:12])
        else begin
            errors++;
            $error("FAIL strb observed=%b expected=%b", strb, instrCode[14:12]);
        end
    endtask

    task automatic step(input logic br);
        busReady = br;
        @(negedge clk);
        cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        push(tag, ev(FE, 1, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        cmp();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [21:0] f_v, d_v, lm_v, sm_v;

    initial begin
        f_v  = ev(FE, 1, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        d_v  = ev(DE, 0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        lm_v = ev(LM, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 1, 0, 0, 0);
        sm_v = ev(SM, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 1, 1, 0, 0);

        instrCode = 32'h0;
        busReady  = 1'b0;
        do_reset("reset_state");

        // add x3,x1,x2; busReady in DECODE must be ignored
        instrCode = 32'h002081B3;
        push("add_fetch", f_v); push("add_decode", d_v);
        push("add_exe", ev(RE, 0, 1, 1, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(1); step(0);

        instrCode = 32'h40208233;
        push("sub_fetch", f_v); push("sub_decode", d_v);
        push("sub_exe", ev(RE, 0, 1, 1, 0, 4'h8, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h4050D093;
        push("srai_fetch", f_v); push("srai_decode", d_v);
        push("srai_exe", ev(IE, 0, 1, 1, 1, 4'hD, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h40008093;
        push("addi30_fetch", f_v); push("addi30_decode", d_v);
        push("addi30_exe", ev(IE, 0, 1, 1, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h00209463;
        push("bne_fetch", f_v); push("bne_decode", d_v);
        push("bne_exe", ev(BE, 0, 1, 0, 0, 4'h1, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h123450B7;
        push("lui_fetch", f_v); push("lui_decode", d_v);
        push("lui_exe", ev(LUE, 0, 1, 1, 0, 4'h0, 3'b010, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h00000097;
        push("auipc_fetch", f_v); push("auipc_decode", d_v);
        push("auipc_exe", ev(AUE, 0, 1, 1, 0, 4'h0, 3'b011, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h008000EF;
        push("jal_fetch", f_v); push("jal_decode", d_v);
        push("jal_exe", ev(JE, 0, 1, 1, 0, 4'h0, 3'b100, 0, 1, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

        instrCode = 32'h000080E7;
        push("jalr_fetch", f_v); push("jalr_decode", d_v);
        push("jalr_exe", ev(JLE, 0, 1, 1, 1, 4'h0, 3'b100, 0, 1, 1, 0, 0, 0, 0));
        step(0); step(0); step(0);

        // lw: ready on the 4th MEM cycle, which coincides with the timeout limit and must complete
        instrCode = 32'h0000A103;
        push("lw_fetch", f_v); push("lw_decode", d_v);
        push("lw_exe", ev(LE, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        push("lw_mem1", lm_v); push("lw_mem2", lm_v); push("lw_mem3", lm_v); push("lw_mem4", lm_v);
        push("lw_wb", ev(LW, 0, 1, 1, 0, 4'h0, 3'b001, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);
        step(0); step(0); step(0); step(1);
        step(0);

        instrCode = 32'h0020A023;
        push("sw_fetch", f_v); push("sw_decode", d_v);
        push("sw_exe", ev(SE, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        push("sw_mem_done", ev(SM, 0, 1, 0, 1, 4'h0, 3'b000, 0, 0, 0, 1, 1, 0, 0));
        step(0); step(0); step(0); step(1);

        // sw with no busReady: trap after 4 MEM cycles, never commits
        push("swto_fetch", f_v); push("swto_decode", d_v);
        push("swto_exe", ev(SE, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        push("swto_mem1", sm_v); push("swto_mem2", sm_v); push("swto_mem3", sm_v); push("swto_mem4", sm_v);
        for (int i = 0; i < 3; i++)
            push("swto_trap", ev(TR, 0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 1));
        step(0); step(0); step(0);
        step(0); step(0); step(0); step(0);
        step(1); step(1); step(0);
        do_reset("reset_after_buserr");

        instrCode = 32'h0000007F;
        push("ill_fetch", f_v); push("ill_decode", d_v);
        push("ill_trap1", ev(TR, 0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 1, 0));
        push("ill_trap2", ev(TR, 0, 0, 0, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 1, 0));
        step(0); step(0); step(0); step(0);
        do_reset("reset_after_illegal");

        // Reset asserted mid L_MEM: busReq must drop without a clock edge
        instrCode = 32'h0000A103;
        push("lwr_fetch", f_v); push("lwr_decode", d_v);
        push("lwr_exe", ev(LE, 0, 0, 0, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        push("lwr_mem1", lm_v);
        step(0); step(0); step(0); step(0);
        #2;
        do_reset("reset_in_lmem");

        instrCode = 32'h002081B3;
        push("add2_fetch", f_v); push("add2_decode", d_v);
        push("add2_exe", ev(RE, 0, 1, 1, 0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
        step(0); step(0); step(0);

`ifdef CU_RETIRE_CNT_EN
        do_reset("reset_before_retire");
        checks++;
        assert (instret === 4'd0)
        else begin
            errors++;
            $error("FAIL instret_reset observed=%0d expected=0", instret);
        end
        instrCode = 32'h00108093;
        for (int k = 0; k < 17; k++) begin
            push("cnt_fetch", f_v); push("cnt_decode", d_v);
            push("cnt_exe", ev(IE, 0, 1, 1, 1, 4'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
            step(0); step(0); step(0);
        end
        checks++;
        assert (instret === 4'd1)
        else begin
            errors++;
            $error("FAIL instret_wrap observed=%0d expected=1", instret);
        end
`endif

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
